// File: rtl/icap_write_ctrl.sv
// ---------------------------------------------------------------------------
// icap_write_ctrl
//
// Streams a partial bitstream into the ICAPE3 wrapper. 32-bit words arrive in
// bitstream order on an AXI-Stream-style slave port. They are gated onto the
// registered ICAP write port under AVAIL/PRERROR control. The controller then
// waits for PRDONE and reports success, PRERROR or a PRDONE timeout. No bit
// swapping is done here because the wrapper does it.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed after the last word for PRDONE to return
//   CNT_W           width of word_cnt
//
// Ports
//   CLK            sole clock, shared by the stream and the ICAP
//   RST_N          asynchronous active-low reset
//   s_tdata        bitstream word, unswapped
//   s_tvalid       word valid
//   s_tlast        last word of the bitstream
//   s_tready       word accepted when s_tvalid && s_tready at CLK rise
//   ICAP_CSIB      registered, to wrapper CSIB
//   ICAP_RDWRB     registered, to wrapper RDWRB
//   ICAP_I         registered, to wrapper I
//   ICAP_AVAIL     from wrapper AVAIL
//   ICAP_PRDONE    from wrapper PRDONE
//   ICAP_PRERROR   from wrapper PRERROR
//   busy           high in any state but IDLE
//   done           one-cycle pulse at session end (success or error)
//   err            sticky error flag, cleared when the next session starts
//   err_code       0 none, 1 PRERROR, 2 PRDONE timeout
//   word_cnt       words written this session, saturating at all-ones
// ---------------------------------------------------------------------------
module icap_write_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic             ICAP_CSIB,
  output logic             ICAP_RDWRB,
  output logic [31:0]      ICAP_I,
  input  logic             ICAP_AVAIL,
  input  logic             ICAP_PRDONE,
  input  logic             ICAP_PRERROR,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] word_cnt
);

  // The timer must hold TIMEOUT_CYCLES and the minimum-wait constant 2.
  localparam int unsigned TIMER_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TIMER_W     = (TIMER_W_RAW < 2) ? 2 : TIMER_W_RAW;
  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] MIN_WAIT    = TIMER_W'(2);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_PRERROR  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WRITE,
    WAIT_DONE,
    DRAIN,
    FINISH
  } state_e;

  state_e             state_q,    state_d;
  logic               csib_q,     csib_d;
  logic               rdwrb_q,    rdwrb_d;
  logic [31:0]        data_q,     data_d;
  logic [CNT_W-1:0]   wordCnt_q,  wordCnt_d;
  logic               err_q,      err_d;
  logic [1:0]         errCode_q,  errCode_d;
  logic [TIMER_W-1:0] timer_q,    timer_d;
  logic               csibPrev_q;

  // RDWRB may only move once CSIB has been high for a full cycle. After a
  // PRERROR in the first WAIT_DONE cycle, CSIB has only just risen when
  // FINISH is reached, so RDWRB then returns high one cycle later from IDLE.
  logic rdwrbMayMove;
  assign rdwrbMayMove = csib_q && csibPrev_q;

  // Next-state and stream-ready logic.
  always_comb begin
    state_d   = state_q;
    csib_d    = 1'b1;
    rdwrb_d   = rdwrb_q;
    data_d    = data_q;
    wordCnt_d = wordCnt_q;
    err_d     = err_q;
    errCode_d = errCode_q;
    timer_d   = timer_q;
    s_tready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rdwrbMayMove) begin
          rdwrb_d = 1'b1;
        end
        if (s_tvalid) begin
          state_d   = ARM;
          wordCnt_d = '0;
          err_d     = 1'b0;
          errCode_d = ERR_NONE;
          timer_d   = '0;
        end
      end

      // One settle cycle: RDWRB drops while CSIB is still high.
      ARM: begin
        rdwrb_d = 1'b0;
        state_d = WRITE;
      end

      // PRERROR masks s_tready, so a word offered alongside it is not taken.
      WRITE: begin
        s_tready = ICAP_AVAIL && !ICAP_PRERROR;
        if (ICAP_PRERROR) begin
          err_d     = 1'b1;
          errCode_d = ERR_PRERROR;
          state_d   = DRAIN;
        end else if (s_tvalid && s_tready) begin
          data_d = s_tdata;
          csib_d = 1'b0;
          if (wordCnt_q != '1) begin
            wordCnt_d = wordCnt_q + CNT_W'(1);
          end
          if (s_tlast) begin
            state_d = WAIT_DONE;
          end
        end
      end

      // PRDONE is ignored for the first two cycles because it may not yet
      // have fallen for this bitstream.
      WAIT_DONE: begin
        if (ICAP_PRERROR) begin
          err_d     = 1'b1;
          errCode_d = ERR_PRERROR;
          state_d   = FINISH;
        end else if (timer_q >= MIN_WAIT && ICAP_PRDONE) begin
          state_d = FINISH;
        end else if (timer_q == TIMEOUT_VAL) begin
          err_d     = 1'b1;
          errCode_d = ERR_TIMEOUT;
          state_d   = FINISH;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // Swallow the rest of a failed bitstream so upstream never stalls.
      DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        if (rdwrbMayMove) begin
          rdwrb_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and ICAP port registers. Reset forces CSIB high at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      csib_q     <= 1'b1;
      rdwrb_q    <= 1'b1;
      data_q     <= '0;
      wordCnt_q  <= '0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_NONE;
      timer_q    <= '0;
      csibPrev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      csib_q     <= csib_d;
      rdwrb_q    <= rdwrb_d;
      data_q     <= data_d;
      wordCnt_q  <= wordCnt_d;
      err_q      <= err_d;
      errCode_q  <= errCode_d;
      timer_q    <= timer_d;
      csibPrev_q <= csib_q;
    end
  end

  assign ICAP_CSIB  = csib_q;
  assign ICAP_RDWRB = rdwrb_q;
  assign ICAP_I     = data_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign err        = err_q;
  assign err_code   = errCode_q;
  assign word_cnt   = wordCnt_q;

endmodule
